// File: rtl/square_pkg.sv
// rtl/square_pkg.sv - shared types and control-bus layout for the sequential squarer
package square_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ITERATE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam int CTRL_LOAD     = 0;
    localparam int CTRL_STEP     = 1;
    localparam int CTRL_COMMIT   = 2;
    localparam int CTRL_WIDTH    = 3;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/square_datapath.sv
// rtl/square_datapath.sv - shift-and-add registers for the squarer, driven only by the control bus
module square_datapath
    import square_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [CTRL_WIDTH-1:0]  i_ctrl,
    input  logic [WIDTH-1:0]       i_root,
    output logic [2*WIDTH-1:0]     o_square
);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_square;

    logic [2*WIDTH-1:0] w_addend;
    logic [2*WIDTH-1:0] w_sum;

    // (2^W-1)^2 fits in 2W bits, so the sum never needs a carry-out
    assign w_addend = r_mplier[0] ? r_mcand : '0;
    assign w_sum    = r_acc + w_addend;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_square <= '0;
        end else begin
            if (i_ctrl[CTRL_LOAD]) begin
                r_mcand  <= {{WIDTH{1'b0}}, i_root};
                r_mplier <= i_root;
                r_acc    <= '0;
            end
            if (i_ctrl[CTRL_STEP] || i_ctrl[CTRL_COMMIT]) begin
                r_acc    <= w_sum;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end
            if (i_ctrl[CTRL_COMMIT]) begin
                r_square <= w_sum;
            end
        end
    end

    assign o_square = r_square;

endmodule

// File: rtl/square_finder.sv
// rtl/square_finder.sv - sequential squarer: FSM, iteration counter and control-bus generation
module square_finder
    import square_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     root,
    output logic                 busy,
    output logic                 valid,
    output logic [2*WIDTH-1:0]   square
);

    localparam int              CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t                r_state;
    logic [CNT_W-1:0]      r_count;
    logic                  r_busy;
    logic                  r_valid;

    logic                  w_last;
    logic [CTRL_WIDTH-1:0] w_ctrl;

    assign w_last = (r_count == LAST_CNT);

    // The final iteration is a commit rather than a step, so only one field is ever high
    always_comb begin
        w_ctrl = '0;
        case (r_state)
            ST_IDLE:    w_ctrl[CTRL_LOAD] = start;
            ST_ITERATE: begin
                if (w_last) w_ctrl[CTRL_COMMIT] = 1'b1;
                else        w_ctrl[CTRL_STEP]   = 1'b1;
            end
            default:    w_ctrl = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_valid <= 1'b0;
                    if (start) begin
                        r_state <= ST_ITERATE;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_ITERATE: begin
                    r_count <= r_count + CNT_W'(1);
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    square_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clock    (clock),
        .reset    (reset),
        .i_ctrl   (w_ctrl),
        .i_root   (root),
        .o_square (square)
    );

    assign busy  = r_busy;
    assign valid = r_valid;

endmodule

// File: tb/tb_square_finder.sv
// tb/tb_square_finder.sv - directed bench with a result scoreboard for square_finder
module tb_square_finder;

    localparam int W = 4;

    logic             clock;
    logic             reset;
    logic             start;
    logic [W-1:0]     root;
    logic             busy;
    logic             valid;
    logic [2*W-1:0]   square;

    int               n_checks = 0;
    int               n_errors = 0;
    logic [2*W-1:0]   sb[$];

    square_finder #(.WIDTH(W)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .root   (root),
        .busy   (busy),
        .valid  (valid),
        .square (square)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Every valid pulse must match the oldest outstanding expectation
    always @(negedge clock) begin
        if (valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 32'(valid), 32'd0);
            end else begin
                logic [2*W-1:0] exp_sq;
                exp_sq = sb.pop_front();
                chk("sb_square", 32'(square), 32'(exp_sq));
            end
        end
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        root  = '0;
        repeat (3) tick();
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_valid",  32'(valid),  32'd0);
        chk("rst_square", 32'(square), 32'd0);
        reset = 1'b1;
        repeat (3) tick();
        chk("idle_busy",   32'(busy),   32'd0);
        chk("idle_square", 32'(square), 32'd0);

        // root=15, single-cycle start: busy for 5 cycles, valid only in the 5th
        root  = 4'd15;
        start = 1'b1;
        sb.push_back(8'd225);
        tick();
        start = 1'b0;
        root  = 4'd0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) tick();
            chk("r15_busy",  32'(busy),  32'd1);
            chk("r15_valid", 32'(valid), (k == 5) ? 32'd1 : 32'd0);
        end
        chk("r15_square", 32'(square), 32'd225);
        tick();
        chk("r15_busy_after",  32'(busy),   32'd0);
        chk("r15_square_hold", 32'(square), 32'd225);
        repeat (2) tick();
        chk("r15_square_hold2", 32'(square), 32'd225);

        // root=9, then root changes and start re-pulses during ITERATE
        root  = 4'd9;
        start = 1'b1;
        sb.push_back(8'd81);
        tick();
        start = 1'b0;
        root  = 4'd3;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("r9_valid",  32'(valid),  32'd1);
        chk("r9_square", 32'(square), 32'd81);
        tick();
        chk("r9_busy_after", 32'(busy), 32'd0);
        repeat (6) tick();
        chk("r9_not_queued", 32'(busy), 32'd0);

        // start held high: one acceptance every 6 cycles, root garbled while iterating
        start = 1'b1;
        for (int r = 0; r < 16; r++) begin
            root = 4'(r);
            sb.push_back(8'(r * r));
            tick();
            chk("strm_busy", 32'(busy), 32'd1);
            for (int k = 0; k < 4; k++) begin
                root = 4'($urandom_range(15, 0));
                tick();
            end
            chk("strm_valid", 32'(valid), 32'd1);
            tick();
            chk("strm_done_idle", 32'(busy), 32'd0);
        end
        start = 1'b0;
        repeat (3) tick();
        chk("strm_drained", 32'(sb.size()), 32'd0);

        // root=12 aborted by reset two edges into ITERATE
        root  = 4'd12;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        chk("abort_busy",   32'(busy),   32'd0);
        chk("abort_valid",  32'(valid),  32'd0);
        chk("abort_square", 32'(square), 32'd0);
        tick();
        reset = 1'b1;
        repeat (6) tick();
        chk("abort_idle", 32'(busy), 32'd0);

        // start during reset is lost
        reset = 1'b0;
        start = 1'b1;
        root  = 4'd7;
        tick();
        start = 1'b0;
        reset = 1'b1;
        tick();
        chk("rst_wins_busy", 32'(busy), 32'd0);

        root  = 4'd12;
        start = 1'b1;
        sb.push_back(8'd144);
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("r12_valid",  32'(valid),  32'd1);
        chk("r12_square", 32'(square), 32'd144);
        tick();

        // root=0 still takes the full latency
        root  = 4'd0;
        start = 1'b1;
        sb.push_back(8'd0);
        tick();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) tick();
            chk("r0_valid", 32'(valid), (k == 5) ? 32'd1 : 32'd0);
        end
        chk("r0_square", 32'(square), 32'd0);
        repeat (3) tick();
        chk("final_drained", 32'(sb.size()), 32'd0);
        chk("final_busy",    32'(busy),      32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
